// File: rtl/counter_timer_ctrl_if.sv
// Command/status bundle between a command source and counter_timer_ctrl.
// master drives commands and config; slave (the controller) drives count and status.
interface counter_timer_ctrl_if #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PRESCALE_W = 4
);
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic                  mode;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic                  irq_ack;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  irq;
    logic                  overrun;

    modport master (
        output start, stop, pause, mode, limit, prescale, irq_ack,
        input  count, busy, irq, overrun
    );

    modport slave (
        input  start, stop, pause, mode, limit, prescale, irq_ack,
        output count, busy, irq, overrun
    );
endinterface

// File: rtl/counter_timer_ctrl.sv
// Programmable one-shot/periodic timer with sticky irq and overrun flags.
// Define COUNTER_TIMER_CTRL_PRESCALE_EN to enable the prescaler; otherwise every RUN cycle ticks.
module counter_timer_ctrl #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PRESCALE_W = 4
) (
    input logic                clock,
    input logic                reset,
    counter_timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;

    localparam logic [WIDTH-1:0] CountOne = 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             irq_q, irq_d;
    logic             overrun_q, overrun_d;
    logic             adv;
    logic             term;

`ifdef COUNTER_TIMER_CTRL_PRESCALE_EN
    localparam logic [PRESCALE_W-1:0] PcOne = 1;

    logic [PRESCALE_W-1:0] pc_q, pc_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
`else
    logic unused_prescale;
    assign unused_prescale = ^bus.prescale;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        irq_d     = irq_q;
        overrun_d = overrun_q;
        adv       = 1'b0;
        term      = 1'b0;
`ifdef COUNTER_TIMER_CTRL_PRESCALE_EN
        pc_d       = pc_q;
        prescale_d = prescale_q;
`endif
        if (bus.stop) begin
            state_d = StIdle;
`ifdef COUNTER_TIMER_CTRL_PRESCALE_EN
            pc_d = '0;
`endif
        end else if (bus.start) begin
            state_d = StRun;
            count_d = '0;
            limit_d = bus.limit;
            mode_d  = bus.mode;
`ifdef COUNTER_TIMER_CTRL_PRESCALE_EN
            pc_d       = '0;
            prescale_d = bus.prescale;
`endif
        end else begin
            case (state_q)
                StRun: begin
                    if (bus.pause) begin
                        state_d = StPaused;
                    end else begin
`ifdef COUNTER_TIMER_CTRL_PRESCALE_EN
                        if (pc_q == prescale_q) begin
                            pc_d = '0;
                            adv  = 1'b1;
                        end else begin
                            pc_d = pc_q + PcOne;
                        end
`else
                        adv = 1'b1;
`endif
                        if (adv) begin
                            if (count_q == limit_q) begin
                                term = 1'b1;
                                // one-shot parks at limit; periodic wraps to 0
                                if (mode_q) count_d = '0;
                                else        state_d = StIdle;
                            end else begin
                                count_d = count_q + CountOne;
                            end
                        end
                    end
                end
                StPaused: if (!bus.pause) state_d = StRun;
                StIdle:   ;
                default:  state_d = StIdle;
            endcase
        end

        // A terminal event keeps irq set even when acknowledged in the same cycle.
        if (term) begin
            irq_d = 1'b1;
            if (bus.irq_ack)  overrun_d = 1'b0;
            else if (irq_q)   overrun_d = 1'b1;
        end else if (bus.irq_ack) begin
            irq_d     = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
`ifdef COUNTER_TIMER_CTRL_PRESCALE_EN
            pc_q       <= '0;
            prescale_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
`ifdef COUNTER_TIMER_CTRL_PRESCALE_EN
            pc_q       <= pc_d;
            prescale_q <= prescale_d;
`endif
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;
endmodule
